ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB slave that consumes the transfers the AHB master VIP drives on the bus interface and maps them onto a synchronous single-port SRAM with 1-cycle read latency. It is the DUT-side stage directly downstream of the bus interface. It handles address/data phase pipelining, byte-lane strobes, read-after-write port conflicts (one wait state) and two-cycle ERROR responses.

Parameters:
HADDR_WIDTH, 32, bus address width.
DATA_WIDTH, 32, bus/SRAM data width (32 or 64).
MEM_BYTES, 65536, SRAM size in bytes (power of 2).
RAM_AW, $clog2(MEM_BYTES/(DATA_WIDTH/8)), derived SRAM word-address width.

Ports:
hclk  in  1  bus clock; all logic on posedge.
hreset  in  1  synchronous active-high reset.
hsel  in  1  slave select.
haddr  in  HADDR_WIDTH  byte address.
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
hwrite  in  1  1=write.
hsize  in  3  log2 of bytes per transfer.
hburst  in  3  accepted, ignored.
hprot  in  4  accepted, ignored.
hwdata  in  DATA_WIDTH  write data (data phase).
hready  in  1  bus-wide ready; qualifies address phase.
hready_out  out  1  slave ready.
hresp  out  2  OKAY=0, ERROR=1.
hrdata  out  DATA_WIDTH  read data.
ram_ce  out  1  SRAM access enable.
ram_we  out  1  SRAM write enable.
ram_be  out  DATA_WIDTH/8  byte enables.
ram_addr  out  RAM_AW  word address.
ram_wdata  out  DATA_WIDTH  write data.
ram_rdata  in  DATA_WIDTH  SRAM data, valid the cycle after a read.

Behaviour:
- Accept: hsel & hready & htrans[1]. IDLE/BUSY or unselected: zero-wait OKAY, no SRAM access.
- Error check at accept, in priority order:
  - haddr >= MEM_BYTES;
  - hsize > log2(DATA_WIDTH/8);
  - misaligned (haddr mod 2^hsize != 0).
  Errored transfers never touch the SRAM.
- Byte lanes are little-endian. ram_be = ((1<<2^hsize)-1) << haddr[log2(DATA_WIDTH/8)-1:0].
- FSM states: IDLE, RD_DATA, WR_DATA, RD_DEFER, ERR1, ERR2.
- Read accept, SRAM free: ram_ce=1, ram_we=0, ram_addr from haddr combinationally, same cycle. Next state RD_DATA: hready_out=1, hrdata=ram_rdata. Zero wait states.
- Write accept: register addr/be. Next state WR_DATA: ram_ce=1, ram_we=1, ram_wdata=hwdata, hready_out=1. Zero wait states. Back-to-back writes have no conflict.
- Read accepted while in WR_DATA (port busy):
  - register the read address; next state RD_DEFER;
  - RD_DEFER: issue read from the registered address, hready_out=0, hresp=OKAY;
  - then RD_DATA completes with hready_out=1.
  - Net cost: exactly 1 wait state.
- Error accept:
  - ERR1: hresp=ERROR, hready_out=0;
  - ERR2: hresp=ERROR, hready_out=1.
  - A transfer accepted during ERR2 is processed normally.
- hrdata = ram_rdata only in RD_DATA; 0 otherwise. hresp=OKAY outside ERR1/ERR2.
- While hready_out=0, nothing is accepted; the master holds its address phase.
- Reset values: state IDLE, hready_out=1, hresp=OKAY, hrdata=0, ram_ce=0, ram_we=0, ram_be=0, address/data registers 0.
- Reset mid-operation: any pending write data phase or deferred read is dropped. No SRAM strobe in any cycle where hreset=1.

Decomposition:
- lvc_ahb_pkg: reuse trans_type_enum, response_type_enum and burst_size_enum. Add typedef ahb_slv_state_enum and function ahb_byte_en(addr_lsb, hsize).
- Slave RTL is flat.
- One sub-module: lvc_sram_sp, a behavioural single-port SRAM (byte-enable write, 1-cycle read). Instantiated beside the slave in the wrapper/bench, not inside it.

Test Plan:
- Write 0x11223344 to 0x0010 (hsize=2), then read 0x0010 -> read has 1 wait state (RD_DEFER), hrdata=0x11223344, hresp=OKAY.
- Write byte 0xAB to 0x0013 (hsize=0) over word 0x00000000, gap of IDLE, read 0x0010 -> ram_be=4'b1000, zero wait, hrdata=0xAB000000.
- Back-to-back NONSEQ reads of 0x0,0x4,0x8 (SEQ, INCR) -> three zero-wait data phases, data in order.
- Read 0x10000 (out of range) -> hready_out 0 then 1 with hresp=ERROR both cycles, ram_ce never high.
- Halfword write at 0x0001 (misaligned) and hsize=3 on 32-bit bus -> each gives two-cycle ERROR, SRAM contents unchanged.
- Assert hreset during WR_DATA of write to 0x20 -> no ram_we pulse, outputs at reset values next cycle, later read of 0x20 returns prior content.

Source files
------------

// File: rtl/lvc_ahb_pkg.sv
// rtl/lvc_ahb_pkg.sv - shared AHB types, slave state encoding and byte-lane helper
package lvc_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } trans_type_enum;

  typedef enum logic [1:0] {
    OKAY  = 2'd0,
    ERROR = 2'd1,
    RETRY = 2'd2,
    SPLIT = 2'd3
  } response_type_enum;

  typedef enum logic [2:0] {
    BURST_SIZE_8BIT    = 3'd0,
    BURST_SIZE_16BIT   = 3'd1,
    BURST_SIZE_32BIT   = 3'd2,
    BURST_SIZE_64BIT   = 3'd3,
    BURST_SIZE_128BIT  = 3'd4,
    BURST_SIZE_256BIT  = 3'd5,
    BURST_SIZE_512BIT  = 3'd6,
    BURST_SIZE_1024BIT = 3'd7
  } burst_size_enum;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_DATA  = 3'd1,
    ST_WR_DATA  = 3'd2,
    ST_RD_DEFER = 3'd3,
    ST_ERR1     = 3'd4,
    ST_ERR2     = 3'd5
  } ahb_slv_state_enum;

  // Little-endian lane mask for up to 8 byte lanes; callers truncate to their bus width.
  function automatic logic [7:0] ahb_byte_en(input logic [2:0] addr_lsb, input logic [2:0] hsize);
    logic [15:0] lanes;
    lanes = (16'd1 << (16'd1 << hsize)) - 16'd1;
    return lanes[7:0] << addr_lsb;
  endfunction

endpackage

// File: rtl/lvc_sram_sp.sv
// rtl/lvc_sram_sp.sv - behavioural single-port SRAM, byte-enable write, 1-cycle read
module lvc_sram_sp #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 14
) (
  input  logic                    clk,
  input  logic                    ce,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**AW];

  // Write enabled lanes, or return the addressed word on the following cycle.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB slave mapping transfers onto a 1-cycle-latency single-port SRAM
module ahb_sram_slave
  import lvc_ahb_pkg::*;
#(
  parameter int HADDR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_BYTES   = 65536,
  parameter int RAM_AW      = $clog2(MEM_BYTES/(DATA_WIDTH/8))
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hsel,
  input  logic [HADDR_WIDTH-1:0]  haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic                    hready,
  output logic                    hready_out,
  output logic [1:0]              hresp,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    ram_ce,
  output logic                    ram_we,
  output logic [DATA_WIDTH/8-1:0] ram_be,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int BYTES = DATA_WIDTH/8;
  localparam int LSB_W = $clog2(BYTES);

  ahb_slv_state_enum state;
  logic [RAM_AW-1:0] addr_q;
  logic [BYTES-1:0]  be_q;

  logic             accept;
  logic             range_err;
  logic             size_err;
  logic             align_err;
  logic             err;
  logic [BYTES-1:0] be_now;
  logic [RAM_AW-1:0] word_addr;
  logic             unused_ok;

  // hready_out gating keeps a stalled address phase from being taken twice.
  assign accept    = hsel & hready & hready_out & htrans[1];
  assign range_err = 64'(haddr) >= 64'(MEM_BYTES);
  assign size_err  = hsize > 3'(LSB_W);
  assign align_err = (haddr[2:0] & 3'((4'd1 << hsize[1:0]) - 4'd1)) != 3'd0;
  assign err       = range_err | size_err | align_err;
  assign be_now    = BYTES'(ahb_byte_en(3'(haddr[LSB_W-1:0]), hsize));
  assign word_addr = haddr[LSB_W +: RAM_AW];
  assign unused_ok = ^{hburst, hprot, htrans[0]};

  // Transfer sequencing with registered handshake and response.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= ST_IDLE;
      hready_out <= 1'b1;
      hresp      <= OKAY;
      addr_q     <= '0;
      be_q       <= '0;
    end else if (accept && err) begin
      state      <= ST_ERR1;
      hready_out <= 1'b0;
      hresp      <= ERROR;
    end else if (accept && hwrite) begin
      state      <= ST_WR_DATA;
      addr_q     <= word_addr;
      be_q       <= be_now;
      hready_out <= 1'b1;
      hresp      <= OKAY;
    end else if (accept && state == ST_WR_DATA) begin
      // Port is busy with the write data phase; replay the read next cycle.
      state      <= ST_RD_DEFER;
      addr_q     <= word_addr;
      be_q       <= be_now;
      hready_out <= 1'b0;
      hresp      <= OKAY;
    end else if (accept || state == ST_RD_DEFER) begin
      state      <= ST_RD_DATA;
      hready_out <= 1'b1;
      hresp      <= OKAY;
    end else if (state == ST_ERR1) begin
      state      <= ST_ERR2;
      hready_out <= 1'b1;
      hresp      <= ERROR;
    end else begin
      state      <= ST_IDLE;
      hready_out <= 1'b1;
      hresp      <= OKAY;
    end
  end

  // SRAM port: write data phase and deferred read own the port; otherwise a fresh read goes straight through.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!hreset) begin
      if (state == ST_WR_DATA) begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_be    = be_q;
        ram_addr  = addr_q;
        ram_wdata = hwdata;
      end else if (state == ST_RD_DEFER) begin
        ram_ce   = 1'b1;
        ram_be   = be_q;
        ram_addr = addr_q;
      end else if (accept && !err && !hwrite) begin
        ram_ce   = 1'b1;
        ram_be   = be_now;
        ram_addr = word_addr;
      end
    end
  end

  assign hrdata = (state == ST_RD_DATA) ? ram_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed self-checking bench for ahb_sram_slave with behavioural SRAM
module tb_ahb_sram_slave;
  import lvc_ahb_pkg::*;

  localparam int HAW = 32;
  localparam int DW  = 32;
  localparam int MB  = 65536;
  localparam int AW  = 14;

  logic          hclk = 1'b0;
  logic          hreset;
  logic          hsel;
  logic [HAW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic          hready_out;
  logic [1:0]    hresp;
  logic [DW-1:0] hrdata;
  logic          ram_ce;
  logic          ram_we;
  logic [DW/8-1:0] ram_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  assign hready = hready_out;

  ahb_sram_slave #(
    .HADDR_WIDTH(HAW), .DATA_WIDTH(DW), .MEM_BYTES(MB), .RAM_AW(AW)
  ) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  lvc_sram_sp #(.DATA_WIDTH(DW), .AW(AW)) sram (
    .clk(hclk), .ce(ram_ce), .we(ram_we), .be(ram_be), .addr(ram_addr),
    .wdata(ram_wdata), .rdata(ram_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr);
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    haddr  = addr;
  endtask

  task automatic idle();
    drive(1'b0, IDLE, 1'b0, 3'd0, 32'h0);
  endtask

  initial begin
    hreset = 1'b1;
    hburst = 3'd1;
    hprot  = 4'h3;
    hwdata = '0;
    idle();
    repeat (3) tick();
    check("rst_hready_out", hready_out, 1);
    check("rst_hresp", hresp, 0);
    check("rst_hrdata", hrdata, 0);
    check("rst_ram_ce", ram_ce, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_be", ram_be, 0);
    hreset = 1'b0;
    tick();

    // Word write then immediate read: one deferred-read wait state
    drive(1, NONSEQ, 1, 3'd2, 32'h10); #1;
    check("s1_wr_addr_no_ce", ram_ce, 0);
    tick(); drive(1, NONSEQ, 0, 3'd2, 32'h10); hwdata = 32'h11223344; #1;
    check("s1_wr_we", ram_we, 1);
    check("s1_wr_be", ram_be, 4'hF);
    check("s1_wr_addr", ram_addr, 4);
    check("s1_wr_wdata", ram_wdata, 32'h11223344);
    check("s1_wr_ready", hready_out, 1);
    tick(); #1;
    check("s1_defer_ready", hready_out, 0);
    check("s1_defer_hresp", hresp, 0);
    check("s1_defer_ce", ram_ce, 1);
    check("s1_defer_we", ram_we, 0);
    check("s1_defer_addr", ram_addr, 4);
    tick(); idle(); #1;
    check("s1_rd_ready", hready_out, 1);
    check("s1_rd_data", hrdata, 32'h11223344);
    check("s1_rd_hresp", hresp, 0);

    // Clear word, byte write to lane 3, IDLE gap, zero-wait read
    tick(); drive(1, NONSEQ, 1, 3'd2, 32'h10); hwdata = 32'h0; #1;
    tick(); drive(1, NONSEQ, 1, 3'd0, 32'h13); hwdata = 32'h0; #1;
    tick(); idle(); hwdata = 32'hAB5A5A5A; #1;
    check("s2_byte_be", ram_be, 4'b1000);
    check("s2_byte_we", ram_we, 1);
    check("s2_byte_addr", ram_addr, 4);
    tick(); hwdata = 32'h0; #1;
    tick(); drive(1, NONSEQ, 0, 3'd2, 32'h10); #1;
    check("s2_rd_ce", ram_ce, 1);
    check("s2_rd_ready", hready_out, 1);
    tick(); idle(); #1;
    check("s2_rd_data", hrdata, 32'hAB000000);
    check("s2_rd_ready_dp", hready_out, 1);

    // Burst writes 0x0/0x4/0x8, then back-to-back reads
    tick(); drive(1, NONSEQ, 1, 3'd2, 32'h0); #1;
    tick(); drive(1, SEQ, 1, 3'd2, 32'h4); hwdata = 32'h01020304; #1;
    tick(); drive(1, SEQ, 1, 3'd2, 32'h8); hwdata = 32'h05060708; #1;
    tick(); idle(); hwdata = 32'h090A0B0C; #1;
    check("s3_wr3_addr", ram_addr, 2);
    check("s3_wr3_we", ram_we, 1);
    tick(); drive(1, NONSEQ, 0, 3'd2, 32'h0); hwdata = 32'h0; #1;
    tick(); drive(1, SEQ, 0, 3'd2, 32'h4); #1;
    check("s3_rd0_data", hrdata, 32'h01020304);
    check("s3_rd0_ready", hready_out, 1);
    tick(); drive(1, SEQ, 0, 3'd2, 32'h8); #1;
    check("s3_rd1_data", hrdata, 32'h05060708);
    check("s3_rd1_ready", hready_out, 1);
    tick(); idle(); #1;
    check("s3_rd2_data", hrdata, 32'h090A0B0C);
    check("s3_rd2_ready", hready_out, 1);

    // Out-of-range read
    tick(); drive(1, NONSEQ, 0, 3'd2, 32'h10000); #1;
    check("s4_addr_ce", ram_ce, 0);
    tick(); idle(); #1;
    check("s4_err1_hresp", hresp, 1);
    check("s4_err1_ready", hready_out, 0);
    check("s4_err1_ce", ram_ce, 0);
    tick(); #1;
    check("s4_err2_hresp", hresp, 1);
    check("s4_err2_ready", hready_out, 1);
    check("s4_err2_ce", ram_ce, 0);
    tick(); #1;
    check("s4_after_hresp", hresp, 0);
    check("s4_after_ready", hready_out, 1);

    // Misaligned halfword write, oversize write, read accepted during ERR2
    drive(1, NONSEQ, 1, 3'd1, 32'h1); hwdata = 32'h0; #1;
    check("s5a_addr_ce", ram_ce, 0);
    tick(); idle(); hwdata = 32'hFFFFFFFF; #1;
    check("s5a_err1_hresp", hresp, 1);
    check("s5a_err1_ready", hready_out, 0);
    check("s5a_err1_we", ram_we, 0);
    tick(); #1;
    check("s5a_err2_hresp", hresp, 1);
    check("s5a_err2_ready", hready_out, 1);
    check("s5a_err2_we", ram_we, 0);
    tick(); drive(1, NONSEQ, 1, 3'd3, 32'h0); #1;
    check("s5b_addr_ce", ram_ce, 0);
    tick(); idle(); #1;
    check("s5b_err1_hresp", hresp, 1);
    check("s5b_err1_ready", hready_out, 0);
    check("s5b_err1_we", ram_we, 0);
    tick(); drive(1, NONSEQ, 0, 3'd2, 32'h0); hwdata = 32'h0; #1;
    check("s5b_err2_hresp", hresp, 1);
    check("s5b_err2_ready", hready_out, 1);
    check("s5b_err2_rd_ce", ram_ce, 1);
    check("s5b_err2_rd_we", ram_we, 0);
    tick(); idle(); #1;
    check("s5_rd_unchanged", hrdata, 32'h01020304);
    check("s5_rd_hresp", hresp, 0);

    // Reset during a write data phase drops the write
    tick(); drive(1, NONSEQ, 1, 3'd2, 32'h20); #1;
    tick(); idle(); hwdata = 32'hCAFEF00D; #1;
    tick(); hwdata = 32'h0; #1;
    tick(); drive(1, NONSEQ, 1, 3'd2, 32'h20); #1;
    tick(); idle(); hreset = 1'b1; hwdata = 32'hDEADBEEF; #1;
    check("s6_rst_we", ram_we, 0);
    check("s6_rst_ce", ram_ce, 0);
    tick(); hreset = 1'b0; hwdata = 32'h0; #1;
    check("s6_post_ready", hready_out, 1);
    check("s6_post_hresp", hresp, 0);
    check("s6_post_hrdata", hrdata, 0);
    check("s6_post_ce", ram_ce, 0);
    drive(1, NONSEQ, 0, 3'd2, 32'h20); #1;
    check("s6_rd_ce", ram_ce, 1);
    tick(); idle(); #1;
    check("s6_rd_data", hrdata, 32'hCAFEF00D);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
